snake_state_writer: RTL and testbench
=====================================

Name: snake_state_writer

Overview:
- Producer side of the 488-bit snake_data bus consumed by the VGA renderer.
- Owns game state: two snakes, apple, hearts timer and stage.
- Advances state on each game step and publishes a tear-free snapshot at frame start.
- Sits between the input/game-tick logic and vga_controller.

Parameters:
- BOARD_W, 40, board columns.
- BOARD_H, 40, board rows.
- MAX_LEN, 49, maximum body length per snake (renderer walks 49 segments).
- INIT_LEN, 3, body length after start.
- HEART_MAX, 100, hearts timer full value (percent).
- HEART_DIV, 4, steps per hearts decrement.

Ports:
- vga_clk  in  1  single clock, same as renderer.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; starts or restarts a game.
- step  in  1  one-cycle game-tick strobe.
- up, down, left, right  in  1 each  snake1 move request; if several are high, priority is up>down>left>right.
- dir2  in  2  snake2 move code: 00 up, 01 right, 10 down, 11 left.
- dir2_valid  in  1  dir2 sampled on step when high.
- apple_pos  in  11  new apple board position, 0..1599.
- apple_load  in  1  loads apple_pos.
- frame_start  in  1  one-cycle pulse at start of vertical sync.
- snake_data  out  488  published snapshot.
- apple_eaten  out  1  one-cycle pulse.
- game_over  out  1  level, high while stage is OVER.

Behaviour:
- snake_data field map:
  - [199:0] 2-bit body codes, entry k at [2k+1:2k]; snake1 uses entries 0..49, snake2 uses 50..99.
  - [231:200] head1 position; [263:232] head2 position.
  - [295:264] length1; [327:296] length2.
  - [359:328] stage.
  - [391:360] head1 index, constant 0; [423:392] head2 index, constant 50.
  - [455:424] apple position; [487:456] hearts timer.
- Body code = direction from a segment to the next one toward the tail: 00 is -40, 01 is +1, 10 is +40, 11 is -1. Stored code = move code XOR 2'b10.
- Stage FSM: IDLE=0, PLAY=2, OVER=3; value 1 is unused.
  - IDLE or OVER --start--> PLAY, with reinit.
  - PLAY --wall hit or hearts reach 0--> OVER.
  - start while in PLAY also reinits and stays in PLAY.
- Reinit values:
  - head1=810, last move right, entries 0..2 = 11, len1=INIT_LEN.
  - head2=830, last move left, entries 50..52 = 01, len2=INIT_LEN.
  - All other codes 0; hearts=HEART_MAX; step counter 0; apple unchanged.
- Reset values:
  - Working and published state: stage=IDLE, reinit values as above, apple=0.
  - snake_data = packed reset state; apple_eaten=0; game_over=0.
- Step handling, PLAY only (steps in IDLE/OVER are ignored). All updates complete in the cycle step is sampled.
  - Move select: a request opposite the last move, or no request, keeps the last move.
  - Wall check uses the old head: up with pos<40, down with pos>=1560, left with col==0, right with col==39. A wall hit sets stage OVER; that snake's head is unchanged and nothing else for that snake updates.
  - Otherwise head += {-40,+1,+40,-1}. The snake's 50-entry code slice shifts toward the tail (entry i+1 <= entry i) and the new stored code enters the head entry.
  - Apple eaten when new head1 or new head2 == apple. Effects: that snake's length += 1 (saturates at MAX_LEN), hearts=HEART_MAX, apple_eaten pulses the next cycle. Both snakes may eat on the same step; apple_eaten is still a single pulse.
  - Hearts: step counter wraps at HEART_DIV. On wrap with no eat that step, hearts -= 1. Hearts reaching 0 sets stage OVER.
- apple_load in the same cycle as step: the step compares against the old apple; the new value loads afterwards.
- Publish: on frame_start, snake_data <= packed working state.
  - step and frame_start in the same cycle publish the pre-step state.
  - No other change to snake_data is permitted.
- Reset asserted mid-game returns all state to reset values immediately and asynchronously.

Decomposition:
- Shared package holds:
  - stage constants IDLE/PLAY/OVER;
  - move codes;
  - field bit offsets for the snake_data map;
  - board constants.
- One sub-module, snake_body_reg: the 50-entry code shift register plus head position, length and wall/move logic. Instantiated twice with different INIT_POS/INIT_CODE values.

Test Plan:
- Reset, then frame_start -> snake_data[359:328]=0, [231:200]=810, [263:232]=830, [295:264]=3, [487:456]=100, game_over=0.
- start, then step with right=1, then frame_start -> head1=811, entries 0..3 = 11; head2=829.
- Snake1 at pos 811 moving right, press left, step -> ignored, head1=812.
- Apple at 812, step snake1 right -> len1=4, apple_eaten pulses once, hearts=100.
- Walk snake1 up from 810 for 21 steps -> at step 21, pos 10 is on row 0, stage=3, game_over=1, head1 stays 10; further steps change nothing.
- No eating, HEART_DIV=4, 400 steps -> hearts hits 0, stage=3. step coincident with frame_start -> published head is the pre-step value.

Source files
------------

// File: rtl/snake_state_writer_pkg.sv
// Shared board constants, stage/move codes and snake_data field layout
// for the snake game-state producer.
package snake_state_writer_pkg;
  localparam int BOARD_W   = 40;
  localparam int BOARD_H   = 40;
  localparam int MAX_LEN   = 49;
  localparam int INIT_LEN  = 3;
  localparam int HEART_MAX = 100;
  localparam int HEART_DIV = 4;
  localparam int N_ENTRY   = 50;
  localparam int POS_W     = 11;
  localparam int LEN_W     = 6;
  localparam int HEART_W   = 7;
  localparam int CNT_W     = 2;
  localparam int DATA_W    = 488;

  localparam logic [POS_W-1:0]   ROW_STEP   = POS_W'(BOARD_W);
  localparam logic [POS_W-1:0]   LAST_COL   = POS_W'(BOARD_W - 1);
  localparam logic [POS_W-1:0]   LAST_ROW0  = POS_W'(BOARD_W * (BOARD_H - 1));
  localparam logic [POS_W-1:0]   INIT_POS1  = 11'd810;
  localparam logic [POS_W-1:0]   INIT_POS2  = 11'd830;
  localparam logic [LEN_W-1:0]   LEN_INIT   = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);
  localparam logic [HEART_W-1:0] HEART_FULL = HEART_W'(HEART_MAX);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(HEART_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd2, OVER = 2'd3} stage_e;

  localparam logic [1:0] MV_UP     = 2'b00;
  localparam logic [1:0] MV_RIGHT  = 2'b01;
  localparam logic [1:0] MV_DOWN   = 2'b10;
  localparam logic [1:0] MV_LEFT   = 2'b11;
  // A body code points back toward the tail, i.e. the reverse of the move.
  localparam logic [1:0] CODE_FLIP = 2'b10;

  localparam int OFS_CODES  = 0;
  localparam int OFS_HEAD1  = 200;
  localparam int OFS_HEAD2  = 232;
  localparam int OFS_LEN1   = 264;
  localparam int OFS_LEN2   = 296;
  localparam int OFS_STAGE  = 328;
  localparam int OFS_HIDX1  = 360;
  localparam int OFS_HIDX2  = 392;
  localparam int OFS_APPLE  = 424;
  localparam int OFS_HEARTS = 456;

  function automatic logic [2*N_ENTRY-1:0] init_codes(input logic [1:0] code);
    logic [2*N_ENTRY-1:0] v;
    v = '0;
    for (int k = 0; k < INIT_LEN; k++) v[2*k +: 2] = code;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] pack_state(
    input logic [2*N_ENTRY-1:0] codes1,
    input logic [2*N_ENTRY-1:0] codes2,
    input logic [POS_W-1:0]     head1,
    input logic [POS_W-1:0]     head2,
    input logic [LEN_W-1:0]     len1,
    input logic [LEN_W-1:0]     len2,
    input logic [1:0]           stage,
    input logic [POS_W-1:0]     apple,
    input logic [HEART_W-1:0]   hearts
  );
    logic [DATA_W-1:0] v;
    v = '0;
    v[OFS_CODES +: 2*N_ENTRY]           = codes1;
    v[OFS_CODES + 2*N_ENTRY +: 2*N_ENTRY] = codes2;
    v[OFS_HEAD1 +: 32]  = 32'(head1);
    v[OFS_HEAD2 +: 32]  = 32'(head2);
    v[OFS_LEN1 +: 32]   = 32'(len1);
    v[OFS_LEN2 +: 32]   = 32'(len2);
    v[OFS_STAGE +: 32]  = 32'(stage);
    v[OFS_HIDX2 +: 32]  = 32'(N_ENTRY);
    v[OFS_APPLE +: 32]  = 32'(apple);
    v[OFS_HEARTS +: 32] = 32'(hearts);
    return v;
  endfunction
endpackage

// File: rtl/snake_state_writer_body.sv
// One snake: head position, last move, length and the 50-entry body code
// shift register, with move selection and wall detection.
module snake_body_reg
  import snake_state_writer_pkg::*;
#(
  parameter logic [POS_W-1:0] INIT_POS  = 11'd810,
  parameter logic [1:0]       INIT_CODE = 2'b11
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   reinit,
  input  logic                   advance,
  input  logic [1:0]             req_move,
  input  logic                   req_valid,
  input  logic [POS_W-1:0]       apple,
  output logic [POS_W-1:0]       head,
  output logic [LEN_W-1:0]       len,
  output logic [2*N_ENTRY-1:0]   codes,
  output logic                   wall_hit,
  output logic                   ate
);
  localparam logic [2*N_ENTRY-1:0] INIT_CODES = init_codes(INIT_CODE);
  localparam logic [1:0]           INIT_MOVE  = INIT_CODE ^ CODE_FLIP;

  logic [1:0]       last_move;
  logic [1:0]       move;
  logic [POS_W-1:0] next_head;
  logic [POS_W-1:0] col;
  logic             wall_raw;

  always_comb begin
    move      = last_move;
    if (req_valid && (req_move != (last_move ^ CODE_FLIP))) move = req_move;
    col       = head % ROW_STEP;
    wall_raw  = 1'b0;
    next_head = head;
    unique case (move)
      MV_UP:    begin wall_raw = (head < ROW_STEP);   next_head = head - ROW_STEP; end
      MV_RIGHT: begin wall_raw = (col == LAST_COL);   next_head = head + 11'd1;    end
      MV_DOWN:  begin wall_raw = (head >= LAST_ROW0); next_head = head + ROW_STEP; end
      MV_LEFT:  begin wall_raw = (col == '0);         next_head = head - 11'd1;    end
    endcase
    wall_hit = advance && wall_raw;
    ate      = advance && !wall_raw && (next_head == apple);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      head      <= INIT_POS;
      last_move <= INIT_MOVE;
      len       <= LEN_INIT;
      codes     <= INIT_CODES;
    end else if (reinit) begin
      head      <= INIT_POS;
      last_move <= INIT_MOVE;
      len       <= LEN_INIT;
      codes     <= INIT_CODES;
    end else if (advance && !wall_raw) begin
      head      <= next_head;
      last_move <= move;
      codes     <= {codes[2*N_ENTRY-3:0], move ^ CODE_FLIP};
      if (ate && (len < LEN_MAX)) len <= len + 1'b1;
    end
  end
endmodule

// File: rtl/snake_state_writer.sv
// Game-state owner for two snakes; steps on game ticks and publishes a
// packed snapshot to the VGA renderer only on frame_start.
// stage | meaning: IDLE waiting for start, PLAY stepping, OVER frozen until start
module snake_state_writer
  import snake_state_writer_pkg::*;
(
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic [1:0]        dir2,
  input  logic              dir2_valid,
  input  logic [POS_W-1:0]  apple_pos,
  input  logic              apple_load,
  input  logic              frame_start,
  output logic [DATA_W-1:0] snake_data,
  output logic              apple_eaten,
  output logic              game_over
);
  localparam logic [DATA_W-1:0] RESET_DATA = pack_state(
    init_codes(MV_RIGHT ^ CODE_FLIP), init_codes(MV_LEFT ^ CODE_FLIP),
    INIT_POS1, INIT_POS2, LEN_INIT, LEN_INIT, IDLE, '0, HEART_FULL);

  stage_e               stage, stage_next;
  logic [HEART_W-1:0]   hearts, hearts_next;
  logic [CNT_W-1:0]     step_cnt;
  logic [POS_W-1:0]     apple;
  logic                 advance, wrap, eat_any;
  logic [1:0]           req1;
  logic                 req1_valid;
  logic [POS_W-1:0]     head1, head2;
  logic [LEN_W-1:0]     len1, len2;
  logic [2*N_ENTRY-1:0] codes1, codes2;
  logic                 wall1, wall2, ate1, ate2;

  assign advance    = step && (stage == PLAY) && !start;
  assign req1_valid = up || down || left || right;
  assign req1       = up ? MV_UP : down ? MV_DOWN : left ? MV_LEFT : MV_RIGHT;
  assign game_over  = (stage == OVER);

  snake_body_reg #(.INIT_POS(INIT_POS1), .INIT_CODE(MV_RIGHT ^ CODE_FLIP)) u_snake1 (
    .vga_clk, .reset, .reinit(start), .advance, .req_move(req1), .req_valid(req1_valid),
    .apple, .head(head1), .len(len1), .codes(codes1), .wall_hit(wall1), .ate(ate1));

  snake_body_reg #(.INIT_POS(INIT_POS2), .INIT_CODE(MV_LEFT ^ CODE_FLIP)) u_snake2 (
    .vga_clk, .reset, .reinit(start), .advance, .req_move(dir2), .req_valid(dir2_valid),
    .apple, .head(head2), .len(len2), .codes(codes2), .wall_hit(wall2), .ate(ate2));

  always_comb begin
    eat_any     = ate1 || ate2;
    wrap        = (step_cnt == CNT_LAST);
    hearts_next = hearts;
    if (eat_any)   hearts_next = HEART_FULL;
    else if (wrap) hearts_next = hearts - 1'b1;
    stage_next = stage;
    if (start) stage_next = PLAY;
    else if (advance && (wall1 || wall2 || (hearts_next == '0))) stage_next = OVER;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) stage <= IDLE;
    else       stage <= stage_next;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hearts      <= HEART_FULL;
      step_cnt    <= '0;
      apple       <= '0;
      apple_eaten <= 1'b0;
      snake_data  <= RESET_DATA;
    end else begin
      apple_eaten <= advance && eat_any;
      if (start) begin
        hearts   <= HEART_FULL;
        step_cnt <= '0;
      end else if (advance) begin
        hearts   <= hearts_next;
        step_cnt <= wrap ? '0 : step_cnt + 1'b1;
      end
      // Step compares against the old apple; the load lands afterwards.
      if (apple_load)  apple <= apple_pos;
      if (frame_start) snake_data <= pack_state(codes1, codes2, head1, head2,
                                                len1, len2, stage, apple, hearts);
    end
  end
endmodule

// File: tb/tb_snake_state_writer.sv
// Self-checking bench for snake_state_writer with a row/column board model.
module tb_snake_state_writer;
  logic         vga_clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, step = 1'b0;
  logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [1:0]   dir2 = 2'd0;
  logic         dir2_valid = 1'b0;
  logic [10:0]  apple_pos = 11'd0;
  logic         apple_load = 1'b0, frame_start = 1'b0;
  logic [487:0] snake_data;
  logic         apple_eaten, game_over;

  int n_vec = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  snake_state_writer dut (
    .vga_clk(vga_clk), .reset(reset), .start(start), .step(step),
    .up(up), .down(down), .left(left), .right(right),
    .dir2(dir2), .dir2_valid(dir2_valid), .apple_pos(apple_pos),
    .apple_load(apple_load), .frame_start(frame_start),
    .snake_data(snake_data), .apple_eaten(apple_eaten), .game_over(game_over));

  // Model: moves 0 up, 1 right, 2 down, 3 left; positions as row*40+col.
  int           m_head[2], m_last[2], m_len[2], m_code[2][50];
  int           m_hearts, m_cnt, m_stage, m_apple;
  logic [487:0] m_pub;
  bit           m_eat;

  logic [3:0] pat1[4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
  int         patmv1[4] = '{1, 2, 3, 0};
  int         pat2[4] = '{3, 0, 1, 2};

  function automatic logic [487:0] pack_model();
    logic [487:0] v;
    v = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 50; k++) v[2*(50*s+k) +: 2] = 2'(m_code[s][k]);
    v[200 +: 32] = 32'(m_head[0]);
    v[232 +: 32] = 32'(m_head[1]);
    v[264 +: 32] = 32'(m_len[0]);
    v[296 +: 32] = 32'(m_len[1]);
    v[328 +: 32] = 32'(m_stage);
    v[392 +: 32] = 32'd50;
    v[424 +: 32] = 32'(m_apple);
    v[456 +: 32] = 32'(m_hearts);
    return v;
  endfunction

  function automatic void m_reinit();
    for (int s = 0; s < 2; s++) for (int k = 0; k < 50; k++) m_code[s][k] = 0;
    for (int k = 0; k < 3; k++) begin m_code[0][k] = 3; m_code[1][k] = 1; end
    m_head = '{810, 830};
    m_last = '{1, 3};
    m_len  = '{3, 3};
    m_hearts = 100;
    m_cnt = 0;
  endfunction

  function automatic void m_reset();
    m_reinit();
    m_apple = 0;
    m_stage = 0;
    m_eat = 0;
    m_pub = pack_model();
  endfunction

  function automatic int prio1(logic [3:0] udlr);
    if (udlr[3]) return 0;
    if (udlr[2]) return 2;
    if (udlr[1]) return 3;
    return 1;
  endfunction

  function automatic int m_next(int pos, int mv);
    int r, c;
    r = pos / 40; c = pos % 40;
    case (mv) 0: r--; 1: c++; 2: r++; default: c--; endcase
    return r * 40 + c;
  endfunction

  function automatic void m_step(int rq0, bit v0, int rq1, bit v1);
    int rq[2]; bit vv[2]; bit wall, ate; int mv, r, c;
    rq = '{rq0, rq1}; vv = '{v0, v1};
    wall = 0; ate = 0;
    for (int s = 0; s < 2; s++) begin
      mv = m_last[s];
      if (vv[s] && rq[s] != (m_last[s] ^ 2)) mv = rq[s];
      r = m_head[s] / 40; c = m_head[s] % 40;
      if ((mv == 0 && r == 0) || (mv == 1 && c == 39) || (mv == 2 && r == 39) || (mv == 3 && c == 0))
        wall = 1;
      else begin
        m_head[s] = m_next(m_head[s], mv);
        m_last[s] = mv;
        for (int k = 49; k > 0; k--) m_code[s][k] = m_code[s][k-1];
        m_code[s][0] = mv ^ 2;
        if (m_head[s] == m_apple) begin
          ate = 1;
          if (m_len[s] < 49) m_len[s]++;
        end
      end
    end
    m_cnt = (m_cnt + 1) % 4;
    if (ate) m_hearts = 100;
    else if (m_cnt == 0) m_hearts--;
    if (wall || m_hearts == 0) m_stage = 3;
    m_eat = ate;
  endfunction

  // Drives one clock of stimulus, advances the model, returns at posedge+1.
  task automatic tick(input logic [3:0] udlr, input int d2, input bit d2v, input bit st,
                      input bit stp, input bit ld, input int lpos, input bit fs);
    {up, down, left, right} = udlr;
    dir2 = 2'(d2); dir2_valid = d2v; start = st; step = stp;
    apple_load = ld; apple_pos = 11'(lpos); frame_start = fs;
    @(posedge vga_clk);
    if (fs) m_pub = pack_model();
    m_eat = 0;
    if (st) begin m_reinit(); m_stage = 2; end
    else if (stp && m_stage == 2) m_step(prio1(udlr), |udlr, d2, d2v);
    if (ld) m_apple = lpos;
    #1;
    {up, down, left, right} = 4'b0;
    dir2_valid = 0; start = 0; step = 0; apple_load = 0; frame_start = 0;
  endtask

  task automatic test_reset();
    m_reset();
    #1 reset = 1'b1;
    #2;
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL reset_data: got %0h want %0h", snake_data, m_pub); end
    n_vec++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_over: got %0b want 0", game_over); end
    n_vec++; if (apple_eaten !== 1'b0) begin n_err++; $display("FAIL reset_eaten: got %0b want 0", apple_eaten); end
    repeat (2) @(posedge vga_clk);
    #1 reset = 1'b0;
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[359:328] !== 32'd0) begin n_err++; $display("FAIL reset_stage: got %0d want 0", snake_data[359:328]); end
    n_vec++; if (snake_data[231:200] !== 32'd810) begin n_err++; $display("FAIL reset_head1: got %0d want 810", snake_data[231:200]); end
    n_vec++; if (snake_data[263:232] !== 32'd830) begin n_err++; $display("FAIL reset_head2: got %0d want 830", snake_data[263:232]); end
    n_vec++; if (snake_data[295:264] !== 32'd3) begin n_err++; $display("FAIL reset_len1: got %0d want 3", snake_data[295:264]); end
    n_vec++; if (snake_data[487:456] !== 32'd100) begin n_err++; $display("FAIL reset_hearts: got %0d want 100", snake_data[487:456]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL reset_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_start_step();
    tick(4'b0, 0, 0, 1, 0, 0, 0, 0);
    tick(4'b0001, 0, 0, 0, 1, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[231:200] !== 32'd811) begin n_err++; $display("FAIL start_head1: got %0d want 811", snake_data[231:200]); end
    n_vec++; if (snake_data[7:0] !== 8'hFF) begin n_err++; $display("FAIL start_codes: got %0h want ff", snake_data[7:0]); end
    n_vec++; if (snake_data[263:232] !== 32'd829) begin n_err++; $display("FAIL start_head2: got %0d want 829", snake_data[263:232]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL start_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_reverse();
    tick(4'b0, 0, 0, 1, 0, 0, 0, 0);
    tick(4'b0001, 0, 0, 0, 1, 0, 0, 0);
    tick(4'b0010, 1, 1, 0, 1, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[231:200] !== 32'd812) begin n_err++; $display("FAIL reverse_head1: got %0d want 812", snake_data[231:200]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL reverse_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_eat();
    tick(4'b0, 0, 0, 1, 0, 0, 0, 0);
    tick(4'b0001, 0, 0, 0, 1, 1, 811, 0);
    n_vec++; if (apple_eaten !== 1'b0) begin n_err++; $display("FAIL eat_oldapple: got %0b want 0", apple_eaten); end
    tick(4'b0, 0, 0, 0, 0, 1, 812, 0);
    tick(4'b0001, 0, 0, 0, 1, 0, 0, 0);
    n_vec++; if (apple_eaten !== 1'b1 || m_eat !== 1'b1) begin n_err++; $display("FAIL eat_pulse: got %0b want 1", apple_eaten); end
    tick(4'b0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++; if (apple_eaten !== 1'b0) begin n_err++; $display("FAIL eat_single: got %0b want 0", apple_eaten); end
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[295:264] !== 32'd4) begin n_err++; $display("FAIL eat_len1: got %0d want 4", snake_data[295:264]); end
    n_vec++; if (snake_data[487:456] !== 32'd100) begin n_err++; $display("FAIL eat_hearts: got %0d want 100", snake_data[487:456]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL eat_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_wall();
    tick(4'b0, 0, 0, 1, 0, 1, 1599, 0);
    for (int i = 0; i < 21; i++) begin
      tick(4'b1000, 0, 0, 0, 1, 0, 0, 0);
      n_vec++; if (game_over !== (m_stage == 3)) begin n_err++; $display("FAIL wall_over[%0d]: got %0b want %0b", i, game_over, m_stage == 3); end
    end
    n_vec++; if (game_over !== 1'b1) begin n_err++; $display("FAIL wall_over_final: got %0b want 1", game_over); end
    for (int i = 0; i < 3; i++) tick(4'($urandom), $urandom_range(0, 3), 1, 0, 1, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[231:200] !== 32'd10) begin n_err++; $display("FAIL wall_head1: got %0d want 10", snake_data[231:200]); end
    n_vec++; if (snake_data[359:328] !== 32'd3) begin n_err++; $display("FAIL wall_stage: got %0d want 3", snake_data[359:328]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL wall_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_hearts();
    int pre_head;
    tick(4'b0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      pre_head = m_head[0];
      tick(pat1[(i/5)%4], pat2[(i/5)%4], 1, 0, 1, 0, 0, i == 399);
      n_vec++; if (game_over !== (m_stage == 3)) begin n_err++; $display("FAIL hearts_over[%0d]: got %0b want %0b", i, game_over, m_stage == 3); end
    end
    n_vec++; if (snake_data[231:200] !== 32'(pre_head)) begin n_err++; $display("FAIL hearts_prestep_head1: got %0d want %0d", snake_data[231:200], pre_head); end
    n_vec++; if (snake_data[359:328] !== 32'd2) begin n_err++; $display("FAIL hearts_prestep_stage: got %0d want 2", snake_data[359:328]); end
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[359:328] !== 32'd3) begin n_err++; $display("FAIL hearts_stage: got %0d want 3", snake_data[359:328]); end
    n_vec++; if (snake_data[487:456] !== 32'd0) begin n_err++; $display("FAIL hearts_zero: got %0d want 0", snake_data[487:456]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL hearts_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_saturate();
    tick(4'b0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      tick(4'b0, 0, 0, 0, 0, 1, m_next(m_head[0], patmv1[(i/5)%4]), 0);
      tick(pat1[(i/5)%4], pat2[(i/5)%4], 1, 0, 1, 0, 0, 0);
      n_vec++; if (apple_eaten !== m_eat) begin n_err++; $display("FAIL sat_eaten[%0d]: got %0b want %0b", i, apple_eaten, m_eat); end
    end
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (snake_data[295:264] !== 32'd49) begin n_err++; $display("FAIL sat_len1: got %0d want 49", snake_data[295:264]); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL sat_pub: got %0h want %0h", snake_data, m_pub); end
  endtask

  task automatic test_random();
    bit st;
    for (int i = 0; i < 600; i++) begin
      st = (m_stage != 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      tick(4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), st,
           1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(760, 860),
           $urandom_range(0, 3) == 0);
      n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL rand_pub[%0d]: got %0h want %0h", i, snake_data, m_pub); end
      n_vec++; if (apple_eaten !== m_eat) begin n_err++; $display("FAIL rand_eaten[%0d]: got %0b want %0b", i, apple_eaten, m_eat); end
      n_vec++; if (game_over !== (m_stage == 3)) begin n_err++; $display("FAIL rand_over[%0d]: got %0b want %0b", i, game_over, m_stage == 3); end
    end
  endtask

  task automatic test_async_reset();
    tick(4'b0, 0, 0, 1, 0, 1, 1599, 0);
    for (int i = 0; i < 21; i++) tick(4'b1000, 0, 0, 0, 1, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++; if (game_over !== 1'b1) begin n_err++; $display("FAIL async_pre_over: got %0b want 1", game_over); end
    #2 reset = 1'b1;
    m_reset();
    #1;
    n_vec++; if (game_over !== 1'b0) begin n_err++; $display("FAIL async_over: got %0b want 0", game_over); end
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL async_data: got %0h want %0h", snake_data, m_pub); end
    @(negedge vga_clk) reset = 1'b0;
    @(posedge vga_clk) #1;
    tick(4'b0, 0, 0, 0, 1, 0, 0, 1);
    n_vec++; if (snake_data !== m_pub) begin n_err++; $display("FAIL async_idle_step: got %0h want %0h", snake_data, m_pub); end
  endtask

  initial begin
    test_reset();
    test_start_step();
    test_reverse();
    test_eat();
    test_wall();
    test_hearts();
    test_saturate();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
